// File: rtl/cpu_writeback.sv
// cpu_writeback: commits an ALU result to the register file or, low byte first, to memory over the 8-bit bus.
// Ports:
//   clk25, rst_n            clock (rising edge) and synchronous active-low reset
//   start                   one-cycle commit request, sampled only while idle
//   wide, dir, modrm        operand size, direction and ModRM byte of the destination
//   ea, result              effective address of the memory operand and the value to commit
//   busy, done              commit in progress / final-write pulse
//   reg_we, reg_idx,
//   reg_wide, reg_data      register-file write port
//   bus_req, bus_a,
//   bus_o, bus_w            byte-bus write port (bus_req steers the core's address mux)
module cpu_writeback #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk25,
   input  logic              rst_n,
   input  logic              start,
   input  logic              wide,
   input  logic              dir,
   input  logic [7:0]        modrm,
   input  logic [ADDR_W-1:0] ea,
   input  logic [DATA_W-1:0] result,
   output logic              busy,
   output logic              done,
   output logic              reg_we,
   output logic [2:0]        reg_idx,
   output logic              reg_wide,
   output logic [DATA_W-1:0] reg_data,
   output logic              bus_req,
   output logic [ADDR_W-1:0] bus_a,
   output logic [7:0]        bus_o,
   output logic              bus_w
);
   typedef enum logic [1:0] {IDLE, REG, MEM_LO, MEM_HI} state_t;
   state_t state, nxt;
   logic wide_q, dir_q;
   logic [7:0] modrm_q;
   logic [ADDR_W-1:0] ea_q;
   logic [DATA_W-1:0] result_q;
   logic idle, s_wide, s_dir, to_reg;
   logic [7:0] s_modrm;
   logic [ADDR_W-1:0] s_ea;
   logic [DATA_W-1:0] s_result;
   logic busy_d, done_d, reg_we_d, reg_wide_d, bus_req_d, bus_w_d;
   logic [2:0] reg_idx_d;
   logic [DATA_W-1:0] reg_data_d;
   logic [ADDR_W-1:0] bus_a_d;
   logic [7:0] bus_o_d;
   // Outputs are registered from the next state, so while idle the operands
   // come straight from the inputs (they are latched on that same edge).
   always_comb begin
      idle       = state == IDLE;
      s_wide     = idle ? wide : wide_q;
      s_dir      = idle ? dir : dir_q;
      s_modrm    = idle ? modrm : modrm_q;
      s_ea       = idle ? ea : ea_q;
      s_result   = idle ? result : result_q;
      to_reg     = s_dir || s_modrm[7:6] == 2'b11;
      nxt        = idle ? (start ? (to_reg ? REG : MEM_LO) : IDLE)
                        : (state == MEM_LO && wide_q) ? MEM_HI : IDLE;
      busy_d     = nxt != IDLE;
      reg_we_d   = nxt == REG;
      bus_req_d  = nxt == MEM_LO || nxt == MEM_HI;
      bus_w_d    = bus_req_d;
      done_d     = nxt == REG || nxt == MEM_HI || (nxt == MEM_LO && !s_wide);
      reg_idx_d  = nxt == REG ? (s_dir ? s_modrm[5:3] : s_modrm[2:0]) : 3'd0;
      reg_wide_d = nxt == REG && s_wide;
      reg_data_d = nxt != REG ? '0
                 : s_wide ? s_result : {{(DATA_W-8){1'b0}}, s_result[7:0]};
      bus_a_d    = nxt == MEM_LO ? s_ea : nxt == MEM_HI ? s_ea + ADDR_W'(1) : '0;
      bus_o_d    = nxt == MEM_LO ? s_result[7:0] : nxt == MEM_HI ? s_result[15:8] : 8'h00;
   end
   always_ff @(posedge clk25) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         reg_we   <= 1'b0;
         reg_idx  <= 3'd0;
         reg_wide <= 1'b0;
         reg_data <= '0;
         bus_req  <= 1'b0;
         bus_a    <= '0;
         bus_o    <= 8'h00;
         bus_w    <= 1'b0;
      end else begin
         state    <= nxt;
         busy     <= busy_d;
         done     <= done_d;
         reg_we   <= reg_we_d;
         reg_idx  <= reg_idx_d;
         reg_wide <= reg_wide_d;
         reg_data <= reg_data_d;
         bus_req  <= bus_req_d;
         bus_a    <= bus_a_d;
         bus_o    <= bus_o_d;
         bus_w    <= bus_w_d;
      end
      if (idle && start) begin
         wide_q   <= wide;
         dir_q    <= dir;
         modrm_q  <= modrm;
         ea_q     <= ea;
         result_q <= result;
      end
   end
endmodule

// File: tb/tb_cpu_writeback.sv
// tb_cpu_writeback: directed and randomized self-checking bench for cpu_writeback.
module tb_cpu_writeback;
   logic clk25 = 1'b0;
   logic rst_n, start, wide, dir;
   logic [7:0] modrm;
   logic [15:0] ea, result;
   logic busy, done, reg_we, reg_wide, bus_req, bus_w;
   logic [2:0] reg_idx;
   logic [15:0] reg_data, bus_a;
   logic [7:0] bus_o;
   int checks = 0;
   int fails = 0;

   typedef struct {
      bit is_mem;
      bit last;
      logic [15:0] addr;
      logic [7:0] byte_v;
      logic [2:0] idx;
      bit wd;
      logic [15:0] rdata;
   } step_t;
   step_t exp_q[$];

   cpu_writeback #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk25(clk25), .rst_n(rst_n), .start(start), .wide(wide), .dir(dir),
      .modrm(modrm), .ea(ea), .result(result), .busy(busy), .done(done),
      .reg_we(reg_we), .reg_idx(reg_idx), .reg_wide(reg_wide), .reg_data(reg_data),
      .bus_req(bus_req), .bus_a(bus_a), .bus_o(bus_o), .bus_w(bus_w)
   );

   always #20 clk25 = ~clk25;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected commit as a list of writes: one register write, or one memory
   // write per byte at consecutive (wrapping) addresses, low byte first.
   task automatic build(input bit w, input bit d, input logic [7:0] m,
                        input logic [15:0] a, input logic [15:0] r);
      step_t s;
      int n;
      exp_q.delete();
      if (d || m[7:6] == 2'b11) begin
         s = '{is_mem: 0, last: 1, addr: 0, byte_v: 0,
               idx: d ? m[5:3] : m[2:0], wd: w, rdata: w ? r : (r & 16'h00FF)};
         exp_q.push_back(s);
      end else begin
         n = w ? 2 : 1;
         for (int i = 0; i < n; i++) begin
            s = '{is_mem: 1, last: (i == n - 1), addr: 16'(a + i),
                  byte_v: 8'(r >> (8 * i)), idx: 0, wd: 0, rdata: 0};
            exp_q.push_back(s);
         end
      end
   endtask

   task automatic check_step(input step_t s, input string tag);
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".done"}, done, s.last);
      chk({tag, ".reg_we"}, reg_we, !s.is_mem);
      chk({tag, ".bus_req"}, bus_req, s.is_mem);
      chk({tag, ".bus_w"}, bus_w, s.is_mem);
      if (s.is_mem) begin
         chk({tag, ".bus_a"}, bus_a, s.addr);
         chk({tag, ".bus_o"}, bus_o, s.byte_v);
      end else begin
         chk({tag, ".reg_idx"}, reg_idx, s.idx);
         chk({tag, ".reg_wide"}, reg_wide, s.wd);
         chk({tag, ".reg_data"}, reg_data, s.rdata);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".done"}, done, 0);
      chk({tag, ".reg_we"}, reg_we, 0);
      chk({tag, ".bus_req"}, bus_req, 0);
      chk({tag, ".bus_w"}, bus_w, 0);
   endtask

   task automatic check_reset(input string tag);
      check_idle(tag);
      chk({tag, ".reg_idx"}, reg_idx, 0);
      chk({tag, ".reg_wide"}, reg_wide, 0);
      chk({tag, ".reg_data"}, reg_data, 0);
      chk({tag, ".bus_a"}, bus_a, 0);
      chk({tag, ".bus_o"}, bus_o, 0);
   endtask

   task automatic tick();
      @(posedge clk25);
      #1;
   endtask

   // Drives a start for one cycle; returns in the first commit cycle.
   task automatic issue(input bit w, input bit d, input logic [7:0] m,
                        input logic [15:0] a, input logic [15:0] r);
      build(w, d, m, a, r);
      wide = w; dir = d; modrm = m; ea = a; result = r; start = 1;
      tick();
      start = 0;
   endtask

   task automatic scramble(input bit with_start);
      wide = 1'($urandom); dir = 1'($urandom); modrm = 8'($urandom);
      ea = 16'($urandom); result = 16'($urandom);
      start = with_start ? 1'($urandom) : 1'b0;
   endtask

   task automatic run(input bit w, input bit d, input logic [7:0] m,
                      input logic [15:0] a, input logic [15:0] r,
                      input string tag, input bit noisy);
      issue(w, d, m, a, r);
      foreach (exp_q[i]) begin
         if (i > 0) tick();
         check_step(exp_q[i], $sformatf("%s.s%0d", tag, i));
         if (noisy) scramble(1);
      end
      tick();
      start = 0;
      check_idle({tag, ".after"});
   endtask

   initial begin
      rst_n = 0; start = 0; wide = 0; dir = 0; modrm = 0; ea = 0; result = 0;
      tick();
      start = 1;
      tick();
      start = 0;
      check_reset("reset");
      rst_n = 1;
      tick();
      check_reset("idle");

      run(1, 1, 8'hD8, 16'h1234, 16'hBEEF, "t1_reg_wide", 0);
      run(0, 0, 8'hC1, 16'h1234, 16'h12AB, "t2_reg_byte", 0);
      run(1, 0, 8'h07, 16'h0200, 16'hA55A, "t3_mem_word", 0);
      run(1, 0, 8'h07, 16'hFFFF, 16'hA55A, "t4_mem_wrap", 0);
      run(0, 0, 8'h46, 16'h0300, 16'h77C3, "mem_byte", 0);

      issue(1, 0, 8'h07, 16'h0200, 16'hA55A);
      check_step(exp_q[0], "t5.s0");
      start = 1; result = 16'h1111; ea = 16'h4000; dir = 1;
      tick();
      check_step(exp_q[1], "t5.s1");
      start = 0;
      tick();
      check_idle("t5.after");
      tick();
      check_idle("t5.quiet");

      issue(1, 0, 8'h07, 16'h0200, 16'hA55A);
      check_step(exp_q[0], "t6.s0");
      rst_n = 0;
      tick();
      check_reset("t6.reset");
      rst_n = 1;
      tick();
      check_idle("t6.release");
      run(1, 0, 8'h07, 16'h0200, 16'hA55A, "t6_again", 0);

      for (int k = 0; k < 60; k++) begin
         run(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
             $sformatf("rnd%0d", k), 1'($urandom));
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            scramble(0);
            tick();
            check_idle($sformatf("rnd%0d.gap", k));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
